// File: rtl/gpr_pkg.sv
// Shared widths, register-select type and arbiter state encoding for the GPR writeback path.
// Latency: none, declarations only.
// Backpressure: not applicable.
package gpr_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [ADDR_W-1:0] gpr_addr_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/gpr_wait_cnt.sv
// Saturating count of consecutive cycles EX was left waiting; at_max forces EX to win.
// Latency: at_max reflects increments from the previous cycle.
// Backpressure: none, pure state counter.
module gpr_wait_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else if (inc && (cnt != 4'(MAX_WAIT))) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign at_max = (cnt == 4'(MAX_WAIT));
endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the single GPR write port between EX and MEM writeback, with a zero-fill init sequence.
// Latency: a granted request reaches gpr_we/gpr_ws/gpr_wdata one cycle later.
// Backpressure: combinational ready per requester, at most one per cycle; both low during init.
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [ADDR_W-1:0]   ex_ws,
    input  logic [DATA_W-1:0]   ex_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_ws,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                gpr_we,
    output logic [ADDR_W-1:0]   gpr_ws,
    output logic [DATA_W-1:0]   gpr_wdata,
    output logic                init_busy,
    output logic [NUM_REGS-1:0] pend_mask
);
    state_t            state, state_nxt;
    gpr_addr_t         idx, idx_nxt;
    logic              we_nxt;
    gpr_addr_t         ws_nxt;
    logic [DATA_W-1:0] wd_nxt;
    logic              run, ex_grant, mem_grant, at_max, wc_inc;

    // Gating with rst keeps the handshake quiet while reset is held, before the first edge.
    assign run       = rst && (state == RUN);
    assign mem_grant = run && !clr_req && mem_valid && !(ex_valid && at_max);
    assign ex_grant  = run && !clr_req && ex_valid && !mem_grant;
    assign ex_ready  = ex_grant;
    assign mem_ready = mem_grant;
    assign init_busy = !run;
    assign wc_inc    = run && !clr_req && ex_valid && !ex_grant;

    gpr_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (wc_inc),
        .clr    (!wc_inc),
        .at_max (at_max)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        we_nxt    = 1'b0;
        ws_nxt    = gpr_ws;
        wd_nxt    = gpr_wdata;
        if (state == INIT) begin
            we_nxt  = 1'b1;
            ws_nxt  = idx;
            wd_nxt  = '0;
            idx_nxt = idx + gpr_addr_t'(1);
            if (idx == gpr_addr_t'(NUM_REGS - 1)) begin
                state_nxt = RUN;
                idx_nxt   = gpr_addr_t'(1);
            end
        end else begin
            if (clr_req) begin
                state_nxt = INIT;
                idx_nxt   = gpr_addr_t'(1);
            end else if (mem_grant) begin
                // r0 is hardwired zero: accept the request but suppress the write.
                we_nxt = (mem_ws != '0);
                ws_nxt = mem_ws;
                wd_nxt = mem_data;
            end else if (ex_grant) begin
                we_nxt = (ex_ws != '0);
                ws_nxt = ex_ws;
                wd_nxt = ex_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= INIT;
            idx       <= gpr_addr_t'(1);
            gpr_we    <= 1'b0;
            gpr_ws    <= '0;
            gpr_wdata <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            gpr_we    <= we_nxt;
            gpr_ws    <= ws_nxt;
            gpr_wdata <= wd_nxt;
        end
    end

    always_comb begin
        pend_mask = '0;
        if (rst) begin
            if (ex_valid)  pend_mask[ex_ws]  = 1'b1;
            if (mem_valid) pend_mask[mem_ws] = 1'b1;
            if (gpr_we)    pend_mask[gpr_ws] = 1'b1;
            pend_mask[0] = 1'b0;
        end
    end
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Randomized and directed bench for gpr_wb_arbiter against a cycle-level reference model.
module tb_gpr_wb_arbiter;
    import gpr_pkg::*;

    localparam int MAXW = 4;

    logic                clk = 1'b0;
    logic                rst, clr_req;
    logic                ex_valid, ex_ready, mem_valid, mem_ready;
    logic [ADDR_W-1:0]   ex_ws, mem_ws, gpr_ws;
    logic [DATA_W-1:0]   ex_data, mem_data, gpr_wdata;
    logic                gpr_we, init_busy;
    logic [NUM_REGS-1:0] pend_mask;

    always #5 clk = ~clk;

    gpr_wb_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_ws     (ex_ws),
        .ex_data   (ex_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_ws    (mem_ws),
        .mem_data  (mem_data),
        .gpr_we    (gpr_we),
        .gpr_ws    (gpr_ws),
        .gpr_wdata (gpr_wdata),
        .init_busy (init_busy),
        .pend_mask (pend_mask)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: zero-fill writes remaining, next fill index, EX stall run length,
    // and the expected registered write port.
    int          m_left, m_idx, m_stall;
    logic        m_we;
    logic [4:0]  m_ws;
    logic [31:0] m_wd;
    bit          m_known;
    bit          acc_ex, acc_mem;

    task automatic model_reset();
        m_left  = 31;
        m_idx   = 1;
        m_stall = 0;
        m_we    = 1'b0;
        m_ws    = 5'd0;
        m_wd    = 32'd0;
        m_known = 1'b1;
    endtask

    task automatic cycle(input bit r, input bit c,
                         input bit ev, input logic [4:0] ews, input logic [31:0] ed,
                         input bit mv, input logic [4:0] mws, input logic [31:0] md);
        bit          in_run, e_ex, e_mem;
        logic [31:0] e_pend;
        rst = r; clr_req = c;
        ex_valid = ev;  ex_ws = ews;  ex_data = ed;
        mem_valid = mv; mem_ws = mws; mem_data = md;
        #4;
        in_run = r && (m_left == 0);
        e_mem  = in_run && !c && mv && !(ev && (m_stall >= MAXW));
        e_ex   = in_run && !c && ev && !e_mem;
        e_pend = 32'd0;
        if (r) begin
            if (ev)   e_pend[ews]  = 1'b1;
            if (mv)   e_pend[mws]  = 1'b1;
            if (m_we) e_pend[m_ws] = 1'b1;
            e_pend[0] = 1'b0;
        end
        chk("ex_ready",  32'(ex_ready),  32'(e_ex));
        chk("mem_ready", 32'(mem_ready), 32'(e_mem));
        chk("init_busy", 32'(init_busy), 32'(!in_run));
        chk("pend_mask", pend_mask, e_pend);
        acc_ex  = e_ex;
        acc_mem = e_mem;

        if (!r) begin
            model_reset();
        end else if (m_left > 0) begin
            m_we = 1'b1; m_ws = 5'(m_idx); m_wd = 32'd0; m_known = 1'b1;
            m_idx++; m_left--; m_stall = 0;
        end else begin
            if (!c && ev && !e_ex) begin
                if (m_stall < MAXW) m_stall++;
            end else begin
                m_stall = 0;
            end
            if (c) begin
                m_left = 31; m_idx = 1; m_we = 1'b0;
            end else if (e_mem) begin
                m_we = (mws != 0); m_ws = mws; m_wd = md; m_known = (mws != 0);
            end else if (e_ex) begin
                m_we = (ews != 0); m_ws = ews; m_wd = ed; m_known = (ews != 0);
            end else begin
                m_we = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        chk("gpr_we", 32'(gpr_we), 32'(m_we));
        if (m_known) begin
            chk("gpr_ws",    32'(gpr_ws), 32'(m_ws));
            chk("gpr_wdata", gpr_wdata,   m_wd);
        end
    endtask

    task automatic idle(input bit r);
        cycle(r, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    bit          cur_ev, cur_mv, rr, cc;
    logic [4:0]  cur_ews, cur_mws;
    logic [31:0] cur_ed, cur_md;

    initial begin
        model_reset();
        acc_ex = 1'b0; acc_mem = 1'b0;
        for (int i = 0; i < 3; i++) idle(1'b0);

        // Zero-fill after reset release: r1..r31, then idle RUN.
        for (int i = 1; i <= 31; i++) begin
            idle(1'b1);
            chk("init_ws", 32'(gpr_ws), 32'(i));
        end
        idle(1'b1);
        chk("init_done_we", 32'(gpr_we), 32'd0);

        // MEM keeps winning until EX has waited MAX_WAIT cycles.
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 5'd4, 32'h12345678, 1'b1, 5'd3, 32'hA5A5A5A5);
            if (k < 5) chk("starve_mem_ws", 32'(gpr_ws), 32'd3);
        end
        chk("starve_ex_ws",   32'(gpr_ws), 32'd4);
        chk("starve_ex_data", gpr_wdata,   32'h12345678);
        idle(1'b1);

        // Write to r0 is accepted and dropped.
        cycle(1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
        chk("r0_we", 32'(gpr_we), 32'd0);
        idle(1'b1);

        // In-flight write shows in pend_mask.
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000BEEF);
        chk("mem7_ws", 32'(gpr_ws), 32'd7);
        chk("mem7_pend", pend_mask, 32'h00000080);
        idle(1'b1);

        // clr_req re-runs zero-fill while EX waits, then EX is granted.
        cycle(1'b1, 1'b1, 1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0);
        for (int i = 1; i <= 31; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0);
            chk("clr_fill_ws", 32'(gpr_ws), 32'(i));
        end
        cycle(1'b1, 1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0);
        chk("clr_ex_ws", 32'(gpr_ws), 32'd9);
        idle(1'b1);

        // Reset mid-init at idx=10 restarts the fill from r1.
        idle(1'b0);
        for (int i = 1; i <= 9; i++) idle(1'b1);
        idle(1'b0);
        chk("midinit_rst_we", 32'(gpr_we), 32'd0);
        idle(1'b1);
        chk("restart_ws", 32'(gpr_ws), 32'd1);
        for (int i = 2; i <= 31; i++) idle(1'b1);

        // Random traffic with hold-while-stalled requesters, occasional clr and reset.
        cur_ev = 1'b0; cur_mv = 1'b0;
        cur_ews = 5'd0; cur_mws = 5'd0; cur_ed = 32'd0; cur_md = 32'd0;
        acc_ex = 1'b0; acc_mem = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!(cur_ev && !acc_ex)) begin
                cur_ev  = ($urandom_range(0, 2) != 0);
                cur_ews = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
                cur_ed  = $urandom;
            end
            if (!(cur_mv && !acc_mem)) begin
                cur_mv  = ($urandom_range(0, 2) != 0);
                cur_mws = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
                cur_md  = $urandom;
            end
            rr = ($urandom_range(0, 299) != 0);
            cc = ($urandom_range(0, 59) == 0);
            cycle(rr, cc, cur_ev, cur_ews, cur_ed, cur_mv, cur_mws, cur_md);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Sequences the single GPR write port (clk, we, ws, wData).
- Shares the port between two writeback requesters: EX (ALU results) and MEM (load data).
- Uses valid/ready handshakes, fixed priority with an anti-starvation override, and a zero-fill init sequence after reset or on request.
- Sits between pipeline writeback and the GPR block; drives its we/ws/wData.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register select width
- NUM_REGS, 32, register count; r0 hardwired zero
- MAX_WAIT, 4, consecutive stalled EX cycles before EX is forced to win; range 1..15

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  synchronous, active-low reset
- clr_req  in  1  pulse: re-run zero-fill of r1..r31
- ex_valid  in  1  EX write request
- ex_ready  out  1  EX request accepted this cycle
- ex_ws  in  ADDR_W  EX destination register
- ex_data  in  DATA_W  EX write data
- mem_valid  in  1  MEM write request
- mem_ready  out  1  MEM request accepted this cycle
- mem_ws  in  ADDR_W  MEM destination register
- mem_data  in  DATA_W  MEM write data
- gpr_we  out  1  GPR write enable, registered
- gpr_ws  out  ADDR_W  GPR write select, registered
- gpr_wdata  out  DATA_W  GPR write data, registered
- init_busy  out  1  high while zero-fill runs
- pend_mask  out  NUM_REGS  registers with an outstanding or in-flight write

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=INIT, idx=1, wait_cnt=0.
  - gpr_we=0, gpr_ws=0, gpr_wdata=0.
  - init_busy=1; ex_ready=mem_ready=0.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle, register gpr_we=1, gpr_ws=idx, gpr_wdata=0, then idx++.
  - After idx=31 is issued, next state is RUN.
  - Exactly 31 writes. init_busy is 1 throughout; both readies are 0.
  - clr_req is ignored in INIT.
- RUN:
  - init_busy=0.
  - Handshake: a transfer occurs when valid && ready. Requesters hold payload stable while valid && !ready.
  - ex_ready and mem_ready are combinational; at most one is 1 per cycle.
  - Grant rule: if mem_valid && !(ex_valid && wait_cnt==MAX_WAIT), grant MEM; else if ex_valid, grant EX.
  - wait_cnt: increments when ex_valid && !ex_ready (saturates at MAX_WAIT); clears on an EX grant or when ex_valid=0.
  - Latency: a granted request appears on gpr_we/ws/wdata on the next cycle.
  - Requests with ws=0 are accepted normally, but next-cycle gpr_we=0 (write dropped).
  - No grant in a cycle → next-cycle gpr_we=0; gpr_ws and gpr_wdata hold their values.
  - clr_req=1 in RUN: no grant that cycle; next state INIT with idx=1, wait_cnt=0.
- pend_mask (combinational):
  - bit ex_ws set if ex_valid; bit mem_ws set if mem_valid; bit gpr_ws set if gpr_we.
  - Bit 0 always 0. All zero while rst=0.
- Both requesters targeting the same register: normal grant rule applies. The loser's write lands later, so the last write wins.
- Reset asserted mid-INIT or mid-RUN: immediate return to reset values. The in-flight write is dropped, since gpr_we=0 on the next cycle.

Decomposition:
- Package gpr_pkg: DATA_W, ADDR_W, NUM_REGS constants; state enum {INIT, RUN}; typedef gpr_addr_t.
- One sub-module, gpr_wait_cnt: the saturating EX starvation counter with inc/clr inputs and an at_max output.
- The FSM, grant logic and output register stay in gpr_wb_arbiter.

Test Plan:
- Release reset, no requests → cycles 1..31 give gpr_we=1 with gpr_ws=1..31 and gpr_wdata=0; cycle 32 gives init_busy=0 and gpr_we=0.
- RUN, mem_valid=1 (ws=3, data=0xA5A5A5A5) and ex_valid=1 (ws=4, data=0x12345678) held with MEM re-presenting each cycle → MEM granted 4 cycles; 5th cycle ex_ready=1; next cycle gpr_ws=4, gpr_wdata=0x12345678.
- RUN, ex_valid=1, ex_ws=0, data=0xFFFFFFFF → ex_ready=1; next cycle gpr_we=0; pend_mask=0.
- RUN, mem_valid=1, ws=7 → pend_mask=0x00000080 that cycle; next cycle gpr_we=1, gpr_ws=7, pend_mask=0x00000080 (in flight).
- RUN, clr_req=1 with ex_valid=1 → ex_ready=0 that cycle; next 31 cycles zero-fill r1..r31; EX granted on the first RUN cycle.
- rst=0 during INIT at idx=10 → next cycle gpr_we=0; after release, zero-fill restarts at gpr_ws=1.
